bg_pixel_fifo: RTL and testbench

//   Background/window pixel FIFO between the BG tile fetcher (upstream) and the pixel mixer (downstream).

---
 rtl/bg_pixel_fifo_if.sv | 39 +++
 rtl/bg_pixel_fifo.sv | 93 +++++++++
 tb/tb_bg_pixel_fifo.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/bg_pixel_fifo_if.sv
// Fetcher <-> pixel FIFO <-> mixer signal bundle.
// master: fetcher/mixer side, drives control and data and observes status.
// slave : the FIFO itself.
interface bg_pixel_fifo_if #(
  parameter int DEPTH = 16
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  // Field layout must stay identical to the copy inside bg_pixel_fifo.
  typedef struct packed {
    logic       bg_prio;
    logic [2:0] palette;
    logic [1:0] color;
  } ppu_pixel_t;

  logic             dot_en;
  logic             flush;
  logic             line_start;
  logic [2:0]       scx_fine;
  logic             push_en;
  ppu_pixel_t       push_px;
  logic             pop_en;
  logic             out_valid;
  ppu_pixel_t       out_px;
  logic             empty;
  logic             full;
  logic [CNT_W-1:0] count;
  logic             overflow;

  modport master (
    output dot_en, flush, line_start, scx_fine, push_en, push_px, pop_en,
    input  out_valid, out_px, empty, full, count, overflow
  );

  modport slave (
    input  dot_en, flush, line_start, scx_fine, push_en, push_px, pop_en,
    output out_valid, out_px, empty, full, count, overflow
  );
endinterface

// File: rtl/bg_pixel_fifo.sv
// Background/window pixel FIFO: first-word-fall-through circular buffer
// between the BG tile fetcher and the pixel mixer. At line start the first
// SCX[2:0] stored pixels are dropped to realise fine horizontal scroll.
module bg_pixel_fifo #(
  parameter  int DEPTH = 16,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = $clog2(DEPTH)
) (
  input logic            clk,
  input logic            reset,
  bg_pixel_fifo_if.slave bus
);

  typedef struct packed {
    logic       bg_prio;
    logic [2:0] palette;
    logic [1:0] color;
  } ppu_pixel_t;

  ppu_pixel_t       mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic [2:0]       discard_cnt;
  logic             overflow;

  logic empty;
  logic full;
  logic head_ok;
  logic clear;
  logic do_discard;
  logic do_pop;
  logic do_remove;
  logic do_push;
  logic do_drop;

  // Status is taken from registered state only, never from this cycle's requests.
  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign head_ok = !empty && (discard_cnt == '0);
  assign clear   = bus.flush || bus.line_start;

  // Discard and pop are mutually exclusive: pop needs discard_cnt == 0.
  // A pop never frees space for a same-cycle push; full is judged before removal.
  assign do_discard = bus.dot_en && (discard_cnt != '0) && !empty;
  assign do_pop     = bus.dot_en && bus.pop_en && head_ok;
  assign do_remove  = do_discard || do_pop;
  assign do_push    = bus.dot_en && bus.push_en && !full;
  assign do_drop    = bus.dot_en && bus.push_en && full;

  // Pointer, occupancy, scroll-discard and overflow bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      discard_cnt <= '0;
      overflow    <= 1'b0;
    end else if (bus.flush) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      discard_cnt <= '0;
      overflow    <= 1'b0;
    end else if (bus.line_start) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      discard_cnt <= bus.scx_fine;
      overflow    <= 1'b0;
    end else begin
      if (do_push)    wr_ptr      <= wr_ptr + 1'b1;
      if (do_remove)  rd_ptr      <= rd_ptr + 1'b1;
      if (do_discard) discard_cnt <= discard_cnt - 1'b1;
      if (do_drop)    overflow    <= 1'b1;
      if (do_push && !do_remove)      count <= count + 1'b1;
      else if (!do_push && do_remove) count <= count - 1'b1;
    end
  end

  // Pixel storage; a push coinciding with flush/line_start/reset is not stored.
  always_ff @(posedge clk) begin
    if (do_push && !clear && !reset) mem[wr_ptr] <= bus.push_px;
  end

  assign bus.out_valid = head_ok;
  assign bus.out_px    = head_ok ? mem[rd_ptr] : '0;
  assign bus.empty     = empty;
  assign bus.full      = full;
  assign bus.count     = count;
  assign bus.overflow  = overflow;

endmodule

// File: tb/tb_bg_pixel_fifo.sv
// Self-checking bench for bg_pixel_fifo: a queue scoreboard holds every
// stored pixel (including ones still pending scroll discard); outputs are
// compared each cycle at the falling edge.
module tb_bg_pixel_fifo;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic reset;

  bg_pixel_fifo_if #(.DEPTH(DEPTH)) bif ();

  bg_pixel_fifo #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  logic [5:0] sb [$];
  int         m_disc = 0;
  bit         m_ovf  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [5:0] mk_px(input int c, input int p, input int b);
    return {1'(b), 3'(p), 2'(c)};
  endfunction

  // One clock: compare outputs with the model, then advance the model by the
  // inputs currently applied, then let the DUT take the same edge.
  task automatic step();
    int sz;
    bit exp_valid;
    @(negedge clk);
    sz = sb.size();
    exp_valid = (sz != 0) && (m_disc == 0);
    chk("count",     32'(bif.count),     32'(sz));
    chk("empty",     32'(bif.empty),     32'(sz == 0));
    chk("full",      32'(bif.full),      32'(sz == DEPTH));
    chk("overflow",  32'(bif.overflow),  32'(m_ovf));
    chk("out_valid", 32'(bif.out_valid), 32'(exp_valid));
    chk("out_px",    32'(bif.out_px),    exp_valid ? 32'(sb[0]) : 32'd0);
    if (reset) begin
      sb.delete();
      m_disc = 0;
      m_ovf  = 1'b0;
    end else if (bif.flush || bif.line_start) begin
      sb.delete();
      m_ovf  = 1'b0;
      m_disc = bif.flush ? 0 : int'(bif.scx_fine);
    end else if (bif.dot_en) begin
      if (m_disc != 0 && sz != 0) begin
        void'(sb.pop_front());
        m_disc--;
      end else if (bif.pop_en && sz != 0) begin
        void'(sb.pop_front());
      end
      if (bif.push_en) begin
        if (sz == DEPTH) m_ovf = 1'b1;
        else sb.push_back(bif.push_px);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bif.flush      = 1'b0;
    bif.line_start = 1'b0;
    bif.push_en    = 1'b0;
    bif.pop_en     = 1'b0;
    bif.dot_en     = 1'b1;
  endtask

  task automatic push_n(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      bif.push_en = 1'b1;
      bif.push_px = mk_px((base + i) % 4, (base + i) % 8, ((base + i) / 4) % 2);
      step();
    end
    bif.push_en = 1'b0;
  endtask

  task automatic pop_n(input int n);
    for (int i = 0; i < n; i++) begin
      bif.pop_en = 1'b1;
      step();
    end
    bif.pop_en = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    bif.scx_fine = 3'd0;
    bif.push_px  = '0;
    idle();
    step();
    step();
    reset = 1'b0;
    chk("rst_count", 32'(bif.count), 32'd0);
    chk("rst_empty", 32'(bif.empty), 32'd1);

    // 8 pushes, colors 0,1,2,3,0,1,2,3, then 8 pops in order
    push_n(8, 0);
    chk("fill8_count", 32'(bif.count), 32'd8);
    chk("fill8_head_color", 32'(bif.out_px.color), 32'd0);
    pop_n(8);
    step();
    chk("drain8_empty", 32'(bif.empty), 32'd1);

    // fine scroll: drop first 3 pixels
    bif.line_start = 1'b1;
    bif.scx_fine   = 3'd3;
    step();
    bif.line_start = 1'b0;
    push_n(8, 0);
    chk("scx3_count", 32'(bif.count), 32'd5);
    chk("scx3_head", 32'(bif.out_px), 32'(mk_px(3, 3, 0)));
    pop_n(5);

    // fill to full, overflow, pop-with-push at full, then flush
    bif.flush = 1'b1;
    step();
    bif.flush = 1'b0;
    push_n(16, 1);
    chk("full16", 32'(bif.full), 32'd1);
    push_n(1, 5);
    chk("ovf_set", 32'(bif.overflow), 32'd1);
    chk("ovf_count", 32'(bif.count), 32'd16);
    bif.pop_en = 1'b1;
    push_n(1, 6);
    bif.pop_en = 1'b0;
    chk("full_pushpop_count", 32'(bif.count), 32'd15);
    bif.flush = 1'b1;
    step();
    bif.flush = 1'b0;
    step();
    chk("flush_count", 32'(bif.count), 32'd0);
    chk("flush_ovf", 32'(bif.overflow), 32'd0);

    // simultaneous push/pop at count 5 across pointer wrap 15->0
    push_n(12, 2);
    pop_n(7);
    chk("pre_wrap_count", 32'(bif.count), 32'd5);
    bif.pop_en = 1'b1;
    push_n(4, 9);
    bif.pop_en = 1'b0;
    chk("wrap_count", 32'(bif.count), 32'd5);
    pop_n(6);

    // dot_en low freezes everything, including pending discard
    bif.line_start = 1'b1;
    bif.scx_fine   = 3'd2;
    step();
    bif.line_start = 1'b0;
    push_n(1, 3);
    bif.dot_en = 1'b0;
    bif.pop_en = 1'b1;
    push_n(3, 7);
    bif.pop_en = 1'b0;
    bif.dot_en = 1'b1;
    chk("hold_count", 32'(bif.count), 32'd1);
    chk("hold_valid", 32'(bif.out_valid), 32'd0);
    push_n(4, 11);
    pop_n(4);

    // flush together with push at count 6: pixel not stored
    push_n(6, 4);
    bif.flush = 1'b1;
    push_n(1, 2);
    bif.flush = 1'b0;
    chk("flushpush_count", 32'(bif.count), 32'd0);
    step();

    // flush beats line_start: no discard loaded
    bif.flush      = 1'b1;
    bif.line_start = 1'b1;
    bif.scx_fine   = 3'd5;
    step();
    idle();
    push_n(1, 1);
    chk("flush_prio_valid", 32'(bif.out_valid), 32'd1);
    pop_n(1);
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
